// File: rtl/mq_push_arbiter_if.sv
// Producer request bus for the multi-queue push arbiter.
// Producers drive the master side; the arbiter is the slave.
interface mq_push_arbiter_if #(
   parameter int N = 4,
   parameter int Q = 4,
   parameter int W = 32
);
   localparam int QW = (Q > 1) ? $clog2(Q) : 1;

   logic [N-1:0]          req_valid;
   logic [N-1:0]          req_ready;
   logic [N-1:0][QW-1:0]  req_q;
   logic [N-1:0][W-1:0]   req_data;

   modport master (
      output req_valid, req_q, req_data,
      input  req_ready
   );

   modport slave (
      input  req_valid, req_q, req_data,
      output req_ready
   );
endinterface

// File: rtl/mq_push_arbiter.sv
// Round-robin, credit-gated sharing of the multi-queue FIFO push port.
// Credits return by snooping the FIFO pop side.
module mq_push_arbiter #(
   parameter int N = 4,
   parameter int Q = 4,
   parameter int D = 16,
   parameter int W = 32,
   localparam int QW = (Q > 1) ? $clog2(Q) : 1,
   localparam int CW = $clog2(D + 1),
   localparam int IW = (N > 1) ? $clog2(N) : 1
) (
   input  logic                 clk,
   input  logic                 rstn,
   mq_push_arbiter_if.slave     rq,
   output logic                 push,
   output logic [QW-1:0]        pushq,
   output logic [W-1:0]         pushDat,
   input  logic [Q-1:0]         queue_full,
   input  logic [Q-1:0]         pop,
   input  logic [Q-1:0]         popRdy,
   output logic [Q-1:0][CW-1:0] credit,
   output logic                 err
);

   logic                 push_q, push_d;
   logic [QW-1:0]        pushq_q, pushq_d;
   logic [W-1:0]         pushdat_q, pushdat_d;
   logic [Q-1:0][CW-1:0] credit_q, credit_d;
   logic [IW-1:0]        rr_q, rr_d;
   logic                 err_q, err_d;

   logic [N-1:0]  elig;
   logic          bad;
   logic          found;
   logic [IW-1:0] g;
   logic [QW-1:0] gq;
   logic [N-1:0]  gnt;
   logic          ovf;
   int            idx;

   // Eligibility only looks at registered credit.
   always_comb begin
      elig = '0;
      bad  = 1'b0;
      for (int i = 0; i < N; i++) begin
         if (rq.req_valid[i]) begin
            if (int'(rq.req_q[i]) >= Q)
               bad = 1'b1;
            else if (credit_q[rq.req_q[i]] != '0)
               elig[i] = 1'b1;
         end
      end
   end

   always_comb begin
      found = 1'b0;
      g     = '0;
      idx   = 0;
      for (int k = 0; k < N; k++) begin
         idx = int'(rr_q) + k;
         if (idx >= N)
            idx = idx - N;
         if (!found && elig[idx]) begin
            found = 1'b1;
            g     = IW'(idx);
         end
      end
   end

   always_comb begin
      gnt = '0;
      if (found)
         gnt[g] = 1'b1;
   end

   assign rq.req_ready = gnt;
   assign gq           = rq.req_q[g];

   always_comb begin
      rr_d = rr_q;
      if (found)
         rr_d = (g == IW'(N - 1)) ? '0 : g + 1'b1;
   end

   // Grant and return on the same queue cancel out.
   always_comb begin
      credit_d = credit_q;
      ovf      = 1'b0;
      for (int q = 0; q < Q; q++) begin
         if (found && int'(gq) == q && !(pop[q] && popRdy[q]))
            credit_d[q] = credit_q[q] - 1'b1;
         else if (pop[q] && popRdy[q] && !(found && int'(gq) == q)) begin
            if (credit_q[q] == CW'(D))
               ovf = 1'b1;
            else
               credit_d[q] = credit_q[q] + 1'b1;
         end
      end
   end

   always_comb begin
      push_d    = found;
      pushq_d   = found ? gq : pushq_q;
      pushdat_d = found ? rq.req_data[g] : pushdat_q;
      err_d     = err_q | ovf | bad
                | (push_q && queue_full[pushq_q]);
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         push_q    <= 1'b0;
         pushq_q   <= '0;
         pushdat_q <= '0;
         credit_q  <= {Q{CW'(D)}};
         rr_q      <= '0;
         err_q     <= 1'b0;
      end else begin
         push_q    <= push_d;
         pushq_q   <= pushq_d;
         pushdat_q <= pushdat_d;
         credit_q  <= credit_d;
         rr_q      <= rr_d;
         err_q     <= err_d;
      end
   end

   assign push    = push_q;
   assign pushq   = pushq_q;
   assign pushDat = pushdat_q;
   assign credit  = credit_q;
   assign err     = err_q;

endmodule
